// File: rtl/aer_rx_fifo_if.sv
// AER input link plus the valid/ready event stream toward the neuron core.
// The sender/core side is the master; the receiver FIFO is the slave.
interface aer_rx_fifo_if #(
   parameter int IMAGE_SIZE_BITS = 8
);
   logic [9:0]                 AERIN_ADDR;
   logic                       AERIN_REQ;
   logic                       AERIN_ACK;
   logic                       EVT_VALID;
   logic [IMAGE_SIZE_BITS-1:0] EVT_ADDR;
   logic                       EVT_READY;

   modport master (
      output AERIN_ADDR, AERIN_REQ, EVT_READY,
      input  AERIN_ACK, EVT_VALID, EVT_ADDR
   );

   modport slave (
      input  AERIN_ADDR, AERIN_REQ, EVT_READY,
      output AERIN_ACK, EVT_VALID, EVT_ADDR
   );
endinterface

// File: rtl/aer_rx_fifo.sv
// AER 4-phase receiver with address range check, feeding a first-word-fall-through
// event FIFO. ACK is withheld while the FIFO is full so no in-range event is lost.
module aer_rx_fifo #(
   parameter int IMAGE_SIZE      = 256,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int FIFO_DEPTH      = 8,
   parameter int CNT_BITS        = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        CLEAR,
   aer_rx_fifo_if.slave                aer,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
   output logic [CNT_BITS-1:0]         EVT_CNT,
   output logic                        ERR_ADDR
);
   localparam int              PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]  FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [10:0]     ADDR_LIM = 11'(IMAGE_SIZE);

   typedef enum logic {IDLE, ACK_HIGH} state_e;

   state_e                     state_q, state_d;
   logic                       ack_q, ack_d;
   logic                       err_q, err_d;
   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]             level_q, level_d;
   logic [CNT_BITS-1:0]        cnt_q, cnt_d;
   logic [IMAGE_SIZE_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [IMAGE_SIZE_BITS-1:0] mem_d [FIFO_DEPTH];
   logic                       in_range, full, accept, push, pop;

   always_comb begin
      in_range = ({1'b0, aer.AERIN_ADDR} < ADDR_LIM);
      // Full comes from the registered level, so a same-cycle pop cannot open a slot.
      full     = (level_q == FULL_LVL);
      accept   = (state_q == IDLE) && aer.AERIN_REQ && (!full || !in_range);
      push     = accept && in_range && !CLEAR;
      pop      = (level_q != '0) && aer.EVT_READY;

      state_d  = state_q;
      ack_d    = ack_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACK_HIGH;
               ack_d   = 1'b1;
            end
         end
         ACK_HIGH: begin
            if (!aer.AERIN_REQ) begin
               state_d = IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      err_d    = err_q;

      if (push) begin
         mem_d[wr_ptr_q] = aer.AERIN_ADDR[IMAGE_SIZE_BITS-1:0];
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (!push && pop) level_d = level_q - 1'b1;
      if (accept && !in_range) err_d = 1'b1;

      // A flush leaves the handshake alone; an event accepted in this cycle is dropped.
      if (CLEAR) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         cnt_d    = '0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign aer.AERIN_ACK = ack_q;
   assign aer.EVT_VALID = (level_q != '0);
   assign aer.EVT_ADDR  = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign FIFO_LEVEL    = level_q;
   assign EVT_CNT       = cnt_q;
   assign ERR_ADDR      = err_q;
endmodule
